// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder: RAM, screen shadow memory, keyboard and status registers,
// plus a write-through FIFO that forwards every screen write to a display controller.
module hack_data_memory #(
   parameter int unsigned RAM_AW  = 14,
   parameter int unsigned SCR_AW  = 13,
   parameter int unsigned FIFO_AW = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [14:0]       addressM,
   input  logic [15:0]       outM,
   input  logic              writeM,
   output logic [15:0]       inM,
   input  logic [15:0]       kbd_code,
   input  logic              kbd_valid,
   output logic              scr_valid,
   input  logic              scr_ready,
   output logic [SCR_AW-1:0] scr_addr,
   output logic [15:0]       scr_data,
   output logic              scr_overflow
);

   localparam int unsigned RamWords  = 1 << RAM_AW;
   localparam int unsigned ScrWords  = 1 << SCR_AW;
   localparam int unsigned FifoDepth = 1 << FIFO_AW;
   localparam int unsigned PtrW      = FIFO_AW + 1;
   localparam int unsigned EntryW    = SCR_AW + 16;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic              w_sel_ram;
   logic              w_sel_scr;
   logic              w_sel_kbd;
   logic              w_sel_stat;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [SCR_AW-1:0] w_scr_idx;

   assign w_sel_ram  = (addressM[14] == 1'b0);
   assign w_sel_scr  = (addressM[14:13] == 2'b10);
   assign w_sel_kbd  = (addressM == 15'h6000);
   assign w_sel_stat = (addressM == 15'h6001);
   assign w_ram_idx  = addressM[RAM_AW-1:0];
   assign w_scr_idx  = addressM[SCR_AW-1:0];

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [15:0]       r_ram [RamWords];
   logic [15:0]       r_scr [ScrWords];
   logic [15:0]       r_kbd;
   logic [EntryW-1:0] r_fifo [FifoDepth];
   logic [PtrW-1:0]   r_wptr;
   logic [PtrW-1:0]   r_rptr;
   logic              r_overflow;

   // RAM and screen are deliberately outside the reset domain so contents survive RST.
   always_ff @(posedge CLK) begin
      if (writeM && w_sel_ram) begin
         r_ram[w_ram_idx] <= outM;
      end
      if (writeM && w_sel_scr) begin
         r_scr[w_scr_idx] <= outM;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_kbd <= '0;
      end else if (kbd_valid) begin
         r_kbd <= kbd_code;
      end
   end

   // ------------------------------------------------------------------
   // Screen-write FIFO
   // ------------------------------------------------------------------
   logic w_empty;
   logic w_full;
   logic w_push_req;
   logic w_pop;
   logic w_push;
   logic w_ovf_event;
   logic w_ovf_clear;
   logic w_overflow_d;

   assign w_empty     = (r_wptr == r_rptr);
   assign w_full      = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                        (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
   assign w_push_req  = writeM && w_sel_scr;
   assign w_pop       = !w_empty && scr_ready;
   // A pop frees the head slot within the same edge, so a full FIFO can still accept.
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_ovf_event = w_push_req && w_full && !w_pop;
   assign w_ovf_clear = writeM && w_sel_stat;

   always_comb begin
      w_overflow_d = r_overflow;
      if (w_ovf_event) begin
         w_overflow_d = 1'b1;
      end else if (w_ovf_clear) begin
         w_overflow_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_fifo[r_wptr[FIFO_AW-1:0]] <= {w_scr_idx, outM};
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_overflow <= w_overflow_d;
      end
   end

   // Head is masked while empty so the outputs read zero out of reset.
   logic [EntryW-1:0] w_head;

   always_comb begin
      w_head = '0;
      if (!w_empty) begin
         w_head = r_fifo[r_rptr[FIFO_AW-1:0]];
      end
   end

   assign scr_valid    = !w_empty;
   assign scr_addr     = w_head[EntryW-1:16];
   assign scr_data     = w_head[15:0];
   assign scr_overflow = r_overflow;

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   always_comb begin
      inM = '0;
      if (w_sel_ram) begin
         inM = r_ram[w_ram_idx];
      end else if (w_sel_scr) begin
         inM = r_scr[w_scr_idx];
      end else if (w_sel_kbd) begin
         inM = r_kbd;
      end else if (w_sel_stat) begin
         inM = {13'b0, w_empty, w_full, r_overflow};
      end
   end

endmodule
